// File: rtl/cart_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : cart_bus_master
// Brief    : CPU-side cartridge bus initiator; issues the mapper write strobe
//            and then one ROM / cart-RAM req/ack memory transaction.
// Revision : 1.0 - initial release
// ============================================================================
module cart_bus_master #(
  parameter int TIMEOUT = 255,
  parameter int ROM_AW  = 23
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic [15:0]       cart_addr,
  output logic              cart_wr,
  output logic [7:0]        cart_di,
  output logic [7:0]        cram_di,
  input  logic [7:0]        cram_do,
  input  logic [9:0]        mbc_bank,
  input  logic [16:0]       cram_addr,
  input  logic              ram_enabled,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ROM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_MBC_WR   = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [7:0] c_open_bus  = 8'hFF;
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_cart_addr;
  logic [7:0]          r_cart_di;
  logic                r_we;
  logic [7:0]          r_cpu_rdata;
  logic [7:0]          r_cram_di;
  logic                r_mem_req;
  logic                r_mem_we;
  logic                r_mem_sel;
  logic [ROM_AW-1:0]   r_mem_addr;
  logic                r_timeout_err;
  logic                r_hold;
  logic [7:0]          r_wait_cnt;
  logic                w_is_rom;
  logic                w_is_cram;
  logic                w_ram_hit;
  logic                w_timeout;
  logic                w_cart_wr;

  assign w_is_rom  = ~r_cart_addr[15];
  assign w_is_cram = (r_cart_addr[15:13] == 3'b101);
  assign w_ram_hit = w_is_cram & ram_enabled;
  assign w_timeout = (r_wait_cnt == c_wait_last);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cart_wr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (r_we)                 w_state_nxt = (w_is_rom || w_is_cram) ? ST_MBC_WR : ST_DONE;
        else if (w_is_rom)        w_state_nxt = ST_MEM_REQ;
        else if (w_ram_hit)       w_state_nxt = ST_MEM_REQ;
        else                      w_state_nxt = ST_DONE;
      end
      ST_MBC_WR: begin
        if (ce) begin
          w_cart_wr   = 1'b1;
          w_state_nxt = w_ram_hit ? ST_MEM_REQ : ST_DONE;
        end
      end
      ST_MEM_REQ: w_state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        // A cart-RAM read lingers one extra cycle so cram_do can reflect cram_di.
        if (r_hold)              w_state_nxt = ST_DONE;
        else if (mem_ack) begin
          if (r_we || w_is_rom)  w_state_nxt = ST_DONE;
        end
        else if (w_timeout)      w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cart_addr   <= 16'h0000;
      r_cart_di     <= 8'h00;
      r_we          <= 1'b0;
      r_cpu_rdata   <= c_open_bus;
      r_cram_di     <= c_open_bus;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_sel     <= 1'b0;
      r_mem_addr    <= '0;
      r_timeout_err <= 1'b0;
      r_hold        <= 1'b0;
      r_wait_cnt    <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_cart_addr   <= cpu_addr;
            r_cart_di     <= cpu_wdata;
            r_we          <= cpu_we;
            r_timeout_err <= 1'b0;
          end
        end
        ST_SETUP: begin
          // Reads finishing without a memory cycle: disabled cart RAM or unmapped space.
          if (!r_we && !w_is_rom && !w_ram_hit)
            r_cpu_rdata <= w_is_cram ? cram_do : c_open_bus;
        end
        ST_MEM_REQ: begin
          r_mem_addr <= w_is_rom ? {mbc_bank, r_cart_addr[12:0]}
                                 : {{(ROM_AW-17){1'b0}}, cram_addr};
          r_mem_sel  <= ~w_is_rom;
          r_mem_we   <= r_we;
          r_mem_req  <= 1'b1;
          r_wait_cnt <= 8'h00;
          r_hold     <= 1'b0;
        end
        ST_MEM_WAIT: begin
          if (r_hold) begin
            r_cpu_rdata <= cram_do;
            r_hold      <= 1'b0;
          end else if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_we) begin
              if (w_is_rom) r_cpu_rdata <= mem_rdata;
              else begin
                r_cram_di <= mem_rdata;
                r_hold    <= 1'b1;
              end
            end
          end else if (w_timeout) begin
            r_mem_req     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_cpu_rdata   <= c_open_bus;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_done    = (r_state == ST_DONE);
  assign cpu_busy    = (r_state != ST_IDLE);
  assign cart_addr   = r_cart_addr;
  assign cart_wr     = w_cart_wr;
  assign cart_di     = r_cart_di;
  assign cram_di     = r_cram_di;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_sel     = r_mem_sel;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_cart_di;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_cart_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_cart_bus_master
// Brief    : Randomized accesses scored against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cart_bus_master;

  localparam int TMO = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        cpu_busy;
  logic [15:0] cart_addr;
  logic        cart_wr;
  logic [7:0]  cart_di;
  logic [7:0]  cram_di;
  logic [7:0]  cram_do;
  logic [9:0]  mbc_bank = 10'h0;
  logic [16:0] cram_addr = 17'h0;
  logic        ram_enabled = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic [22:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h0;
  logic        timeout_err;
  logic [7:0]  rtc_val = 8'hFF;

  // Mapper stand-in: RAM data is a fixed scramble of cram_di, otherwise an RTC/open-bus value.
  assign cram_do = ram_enabled ? (cram_di ^ 8'hA5) : rtc_val;

  cart_bus_master #(.TIMEOUT(TMO), .ROM_AW(23)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
    .cart_addr(cart_addr), .cart_wr(cart_wr), .cart_di(cart_di),
    .cram_di(cram_di), .cram_do(cram_do), .mbc_bank(mbc_bank), .cram_addr(cram_addr),
    .ram_enabled(ram_enabled), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        is_read;
    logic [7:0]  rdata;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          n_cartwr;
    int          n_mreq;
    logic        terr;
    logic [7:0]  cram_di;
    int          lat_min;
    int          lat_max;
    int          issue_cyc;
  } exp_done_t;

  typedef struct {
    logic [22:0] addr;
    logic        sel;
    logic        we;
    logic [7:0]  wdata;
  } exp_mem_t;

  exp_done_t   done_q[$];
  exp_mem_t    mem_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          ce_div = 1;
  int          cur_delay = 0;
  logic [7:0]  cur_rd = 8'h0;
  int          late_ack_req = 0;
  logic [7:0]  model_cram_di = 8'hFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_total++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin : ce_gen
    forever begin
      @(posedge clk_sys);
      cyc++;
      #1;
      ce = ((cyc % ce_div) == 0);
    end
  end

  initial begin : responder
    int   k;
    logic acked;
    int   late_seen;
    k = 0; acked = 1'b0; late_seen = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      if (late_ack_req != late_seen) begin
        late_seen = late_ack_req;
        mem_ack   = 1'b1;
      end else if (mem_req && reset_n) begin
        if (!acked && k == cur_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = cur_rd;
          acked     = 1'b1;
        end
        k++;
      end else begin
        k = 0;
        acked = 1'b0;
      end
    end
  end

  initial begin : monitor
    int        n_cw;
    int        n_mr;
    logic      prev_mr;
    exp_done_t e;
    exp_mem_t  m;
    n_cw = 0; n_mr = 0; prev_mr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        n_cw = 0; n_mr = 0; prev_mr = 1'b0;
      end else begin
        if (cart_wr) begin
          n_cw++;
          chk("cart_wr_with_ce", 32'(ce), 32'd1);
        end
        if (mem_req) begin
          n_mr++;
          if (!prev_mr) begin
            if (mem_q.size() == 0) fail_now("unexpected_mem_req", 1, 0);
            else begin
              m = mem_q.pop_front();
              chk("mem_addr", 32'(mem_addr), 32'(m.addr));
              chk("mem_sel", 32'(mem_sel), 32'(m.sel));
              chk("mem_we", 32'(mem_we), 32'(m.we));
              chk("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
            end
          end
        end
        prev_mr = mem_req;
        if (cpu_done) begin
          if (done_q.size() == 0) fail_now("unexpected_cpu_done", 1, 0);
          else begin
            e = done_q.pop_front();
            if (e.is_read) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
            chk("cart_wr_cycles", n_cw, e.n_cartwr);
            chk("mem_req_cycles", n_mr, e.n_mreq);
            chk("timeout_err", 32'(timeout_err), 32'(e.terr));
            chk("cram_di", 32'(cram_di), 32'(e.cram_di));
            chk("cart_addr", 32'(cart_addr), 32'(e.addr));
            chk("cart_di", 32'(cart_di), 32'(e.wdata));
            chk("busy_at_done", 32'(cpu_busy), 32'd1);
            if (e.lat_max < (1 << 30)) begin
              n_total++;
              if ((cyc - e.issue_cyc) >= e.lat_min && (cyc - e.issue_cyc) <= e.lat_max) n_pass++;
              else $display("FAIL latency: got %0d cycles expected %0d..%0d",
                            cyc - e.issue_cyc, e.lat_min, e.lat_max);
            end
          end
          n_cw = 0; n_mr = 0;
        end
      end
    end
  end

  // Predict the whole transaction from the access rules, then drive the request.
  task automatic start_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [9:0] bank, input logic [16:0] caddr, input logic ren,
                           input logic [7:0] rtc, input int delay, input logic [7:0] rd);
    exp_done_t e;
    exp_mem_t  m;
    int        region;
    logic      mem;
    logic      tmo;
    @(posedge clk_sys);
    #1;
    mbc_bank = bank; cram_addr = caddr; ram_enabled = ren; rtc_val = rtc;
    cur_delay = delay; cur_rd = rd;
    region = (addr[15] == 1'b0) ? 0 : ((addr[15:13] == 3'b101) ? 1 : 2);
    mem = (region == 0 && !we) || (region == 1 && ren);
    tmo = mem && (delay >= TMO);
    e.is_read  = !we;
    e.addr     = addr;
    e.wdata    = wd;
    e.n_cartwr = (we && region != 2) ? 1 : 0;
    e.n_mreq   = !mem ? 0 : (tmo ? TMO : delay + 1);
    e.terr     = tmo;
    if (region == 2 || tmo) e.rdata = 8'hFF;
    else if (region == 0)   e.rdata = rd;
    else if (ren)           e.rdata = rd ^ 8'hA5;
    else                    e.rdata = rtc;
    if (!we && region == 1 && ren && !tmo) model_cram_di = rd;
    e.cram_di = model_cram_di;
    e.lat_min = 0;
    e.lat_max = 1 << 30;
    if (!we && region == 0 && !tmo) begin e.lat_min = 4 + delay; e.lat_max = 4 + delay; end
    if (!we && region == 1 && !ren) e.lat_max = 3;
    e.issue_cyc = cyc;
    if (mem) begin
      m.addr  = (region == 0) ? 23'(int'(bank) * 8192 + int'(addr % 16'd8192)) : 23'(caddr);
      m.sel   = (region == 1);
      m.we    = we;
      m.wdata = wd;
      mem_q.push_back(m);
    end
    done_q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk_sys);
    #1;
    cpu_req = 1'b0;
    cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
  endtask

  task automatic finish_txn(input logic poke);
    int guard;
    guard = 0;
    if (poke) begin
      @(posedge clk_sys); #1; cpu_req = 1'b1;
      @(posedge clk_sys); #1; cpu_req = 1'b0;
    end
    while (done_q.size() != 0 && guard < 2000) begin
      @(posedge clk_sys);
      guard++;
    end
    if (done_q.size() != 0) begin
      fail_now("done_wait_expired", guard, 2000);
      done_q.delete();
    end
    chk("pending_mem_req", 32'(mem_q.size()), 32'd0);
    mem_q.delete();
    repeat (2) @(posedge clk_sys);
    #1;
    chk("idle_busy", 32'(cpu_busy), 32'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] ra;
    int          rsel;
    int          guard;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    chk("rst_cram_di", 32'(cram_di), 32'hFF);
    chk("rst_cpu_done", 32'(cpu_done), 32'd0);
    chk("rst_cpu_busy", 32'(cpu_busy), 32'd0);
    chk("rst_cart_wr", 32'(cart_wr), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_cart_addr", 32'(cart_addr), 32'd0);
    reset_n = 1'b1;

    ce_div = 1;
    start_txn(1'b0, 16'h4123, 8'h00, 10'h005, 17'h0, 1'b0, 8'hFF, 1, 8'h3C);
    finish_txn(1'b0);
    ce_div = 4;
    start_txn(1'b1, 16'h2000, 8'h07, 10'h001, 17'h0, 1'b0, 8'hFF, 0, 8'h00);
    finish_txn(1'b1);
    start_txn(1'b1, 16'hA010, 8'h55, 10'h001, 17'h02010, 1'b1, 8'hFF, 2, 8'h00);
    finish_txn(1'b0);
    ce_div = 1;
    start_txn(1'b0, 16'hA123, 8'h00, 10'h000, 17'h00001, 1'b0, 8'hFF, 0, 8'h00);
    finish_txn(1'b1);
    start_txn(1'b0, 16'hBFFF, 8'h00, 10'h000, 17'h1FFFF, 1'b1, 8'h00, 2, 8'h5A);
    finish_txn(1'b0);
    start_txn(1'b0, 16'h0042, 8'h00, 10'h003, 17'h0, 1'b0, 8'hFF, 255, 8'h11);
    finish_txn(1'b0);
    start_txn(1'b0, 16'h0043, 8'h00, 10'h003, 17'h0, 1'b0, 8'hFF, 0, 8'h22);
    finish_txn(1'b0);
    start_txn(1'b0, 16'hC000, 8'h00, 10'h003, 17'h0, 1'b1, 8'h12, 0, 8'h22);
    finish_txn(1'b0);

    // Reset while a ROM read waits for an acknowledge that never comes.
    start_txn(1'b0, 16'h1234, 8'h00, 10'h2AA, 17'h0, 1'b0, 8'h00, 255, 8'h00);
    guard = 0;
    while (!mem_req && guard < 50) begin @(posedge clk_sys); #1; guard++; end
    chk("mem_req_before_reset", 32'(mem_req), 32'd1);
    @(posedge clk_sys);
    #2;
    reset_n = 1'b0;
    done_q.delete();
    mem_q.delete();
    model_cram_di = 8'hFF;
    #1;
    chk("reset_drops_mem_req", 32'(mem_req), 32'd0);
    chk("reset_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    chk("reset_cpu_busy", 32'(cpu_busy), 32'd0);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    late_ack_req++;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    chk("late_ack_busy", 32'(cpu_busy), 32'd0);
    start_txn(1'b0, 16'h1234, 8'h00, 10'h2AA, 17'h0, 1'b0, 8'h00, 0, 8'hC3);
    finish_txn(1'b0);

    for (int i = 0; i < 300; i++) begin
      rsel = $urandom_range(0, 9);
      ra   = 16'($urandom);
      if (rsel < 4)      ra[15] = 1'b0;
      else if (rsel < 8) ra[15:13] = 3'b101;
      ce_div = $urandom_range(1, 4);
      start_txn(1'($urandom_range(0, 1)), ra, 8'($urandom), 10'($urandom), 17'($urandom),
                1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, TMO + 1), 8'($urandom));
      finish_txn($urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
